// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath:
// opcode and memory-ready in, every mux select and write enable out.
interface mips_multicycle_control_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] instr;
  logic                mem_ready;
  logic                PCWrite;
  logic                Branch;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemToReg;
  logic                RegWrite;
  logic                RegDst;
  logic                AluSrcA;
  logic [1:0]          AluSrcB;
  logic [1:0]          AluOp;
  logic [1:0]          PCSrc;
  logic                illegal_op;
  logic [3:0]          state;

  modport master (
    input  instr, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegWrite, RegDst, AluSrcA, AluSrcB, AluOp, PCSrc, illegal_op, state
  );

  modport slave (
    output instr, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegWrite, RegDst, AluSrcA, AluSrcB, AluOp, PCSrc, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control FSM for the MIPS_V2 shared-ALU/shared-memory datapath,
// with optional stall-on-memory handshake and illegal-opcode trapping.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RESET      | held in reset, all controls low
// FETCH      | read instruction, PC <= PC + 4 when memory is ready
// DECODE     | dispatch on opcode, precompute branch target
// MEMADR     | base + sign-extended offset for lw/sw
// MEMREAD    | data read, waits for memory
// MEMWB      | write loaded data to rt
// MEMWRITE   | data write, waits for memory
// EXECUTE    | R-type ALU operation
// ALUWB      | write ALU result to rd
// BRANCH     | beq compare, PC <= target if zero
// ADDIEXEC   | rs + sign-extended immediate
// ADDIWB     | write addi result to rt
// JUMP       | PC <= jump target
// TRAP       | unsupported opcode, one-cycle illegal_op pulse
module mips_multicycle_control #(
  parameter int OPCODE_W      = 6,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctl_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  state_t state_q;
  state_t state_nxt;
  ctl_t   ctl_q;
  logic   ready;

  // With the handshake disabled the memory is treated as single-cycle.
  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RESET:    state_nxt = S_FETCH;
      S_FETCH:    state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.instr)
          OP_RTYPE:      state_nxt = S_EXECUTE;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_ADDI:       state_nxt = S_ADDIEXEC;
          OP_J:          state_nxt = S_JUMP;
          default:       state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (bus.instr == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_ADDIEXEC: state_nxt = S_ADDIWB;
      S_ADDIWB:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_FETCH;
      default:    state_nxt = S_RESET;
    endcase
  end

  // Moore decode, evaluated on the next state so the outputs register alongside it.
  function automatic ctl_t decode_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch   = 1'b1;
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMREAD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
      end
      S_ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      ctl_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ctl_q   <= decode_ctl(state_nxt);
    end
  end

  // Fetch-time PC and IR writes are the only ready-gated controls.
  assign bus.PCWrite    = ctl_q.pcwrite | (ctl_q.fetch & ready);
  assign bus.IRWrite    = ctl_q.fetch & ready;
  assign bus.Branch     = ctl_q.branch;
  assign bus.IorD       = ctl_q.iord;
  assign bus.MemRead    = ctl_q.memread;
  assign bus.MemWrite   = ctl_q.memwrite;
  assign bus.MemToReg   = ctl_q.memtoreg;
  assign bus.RegWrite   = ctl_q.regwrite;
  assign bus.RegDst     = ctl_q.regdst;
  assign bus.AluSrcA    = ctl_q.alusrca;
  assign bus.AluSrcB    = ctl_q.alusrcb;
  assign bus.AluOp      = ctl_q.aluop;
  assign bus.PCSrc      = ctl_q.pcsrc;
  assign bus.illegal_op = ctl_q.illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level phase-list model with
// random opcodes and memory stalls, plus directed cycle-count and reset checks.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctl_t;

  typedef enum int {P_F, P_D, P_MADR, P_MRD, P_MWB, P_MWR, P_EXE, P_AWB,
                    P_BR, P_AEX, P_IWB, P_J, P_TRAP} ph_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instr = '0;
  logic       mem_ready = 1'b0;
  bit         sel_b = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ph_t        plan_q[$];
  int         t_cyc, t_rw, t_mw, t_mwi, t_mrd, t_ill, t_pcw, t_brn;

  mips_multicycle_control_if #(.OPCODE_W(6)) bus_a ();
  mips_multicycle_control_if #(.OPCODE_W(6)) bus_b ();

  assign bus_a.instr     = instr;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.instr     = instr;
  assign bus_b.mem_ready = mem_ready;

  mips_multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  mips_multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  ctl_t obs_a, obs_b;
  assign obs_a = {bus_a.PCWrite, bus_a.Branch, bus_a.IorD, bus_a.MemRead, bus_a.MemWrite,
                  bus_a.IRWrite, bus_a.MemToReg, bus_a.RegWrite, bus_a.RegDst, bus_a.AluSrcA,
                  bus_a.AluSrcB, bus_a.AluOp, bus_a.PCSrc, bus_a.illegal_op};
  assign obs_b = {bus_b.PCWrite, bus_b.Branch, bus_b.IorD, bus_b.MemRead, bus_b.MemWrite,
                  bus_b.IRWrite, bus_b.MemToReg, bus_b.RegWrite, bus_b.RegDst, bus_b.AluSrcA,
                  bus_b.AluSrcB, bus_b.AluOp, bus_b.PCSrc, bus_b.illegal_op};

  function automatic ctl_t obs();
    return sel_b ? obs_b : obs_a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Control values each instruction phase must present; r is the effective memory-ready.
  function automatic ctl_t exp_ctl(ph_t p, logic r);
    ctl_t c;
    c = '0;
    case (p)
      P_F:    begin c.memread = 1; c.alusrcb = 2'b01; c.pcwrite = r; c.irwrite = r; end
      P_D:    c.alusrcb = 2'b11;
      P_MADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      P_MRD:  begin c.memread = 1; c.iord = 1; end
      P_MWB:  begin c.regwrite = 1; c.memtoreg = 1; end
      P_MWR:  begin c.memwrite = 1; c.iord = 1; end
      P_EXE:  begin c.alusrca = 1; c.aluop = 2'b10; end
      P_AWB:  begin c.regwrite = 1; c.regdst = 1; end
      P_BR:   begin c.alusrca = 1; c.aluop = 2'b01; c.branch = 1; c.pcsrc = 2'b01; end
      P_AEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      P_IWB:  c.regwrite = 1;
      P_J:    begin c.pcwrite = 1; c.pcsrc = 2'b10; end
      P_TRAP: c.illegal = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic build_plan(input logic [5:0] op);
    plan_q = {};
    plan_q.push_back(P_F);
    plan_q.push_back(P_D);
    case (op)
      6'b000000: begin plan_q.push_back(P_EXE);  plan_q.push_back(P_AWB); end
      6'b100011: begin plan_q.push_back(P_MADR); plan_q.push_back(P_MRD); plan_q.push_back(P_MWB); end
      6'b101011: begin plan_q.push_back(P_MADR); plan_q.push_back(P_MWR); end
      6'b000100: plan_q.push_back(P_BR);
      6'b001000: begin plan_q.push_back(P_AEX);  plan_q.push_back(P_IWB); end
      6'b000010: plan_q.push_back(P_J);
      default:   plan_q.push_back(P_TRAP);
    endcase
  endtask

  // Entered and left just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input bit hs);
    logic r, eff;
    bit   more;
    int   stalls;
    build_plan(op);
    foreach (plan_q[i]) begin
      stalls = 0;
      do begin
        r = ($urandom_range(0, 3) != 0) || (stalls >= 6);
        eff = hs ? r : 1'b1;
        mem_ready = r;
        instr = (plan_q[i] == P_D || plan_q[i] == P_MADR) ? op : 6'($urandom);
        @(negedge clk);
        check($sformatf("ctl op=%02h phase=%0d", op, plan_q[i]), 32'(obs()),
              32'(exp_ctl(plan_q[i], eff)));
        @(posedge clk);
        #1;
        more = (plan_q[i] == P_F || plan_q[i] == P_MRD || plan_q[i] == P_MWR) && !eff;
        stalls++;
      end while (more);
    end
  endtask

  // Observes the DUT alone from FETCH back to FETCH and tallies controls.
  task automatic count_instr(input logic [5:0] op, input int stall_n, input bit hold_low);
    ctl_t o;
    int   left;
    left = stall_n;
    t_cyc = 0; t_rw = 0; t_mw = 0; t_mwi = 0; t_mrd = 0; t_ill = 0; t_pcw = 0; t_brn = 0;
    instr = op;
    for (int k = 0; k < 40; k++) begin
      o = obs();
      if (hold_low) mem_ready = 1'b0;
      else if ((o.memread && o.iord) || o.memwrite) begin
        mem_ready = (left == 0);
        if (left > 0) left--;
      end else mem_ready = 1'b1;
      @(negedge clk);
      o = obs();
      t_rw  += int'(o.regwrite);
      t_mw  += int'(o.memwrite);
      t_mwi += int'(o.memwrite && o.iord);
      t_mrd += int'(o.memread && o.iord);
      t_ill += int'(o.illegal);
      if (o.pcwrite && !(o.memread && !o.iord)) t_pcw++;
      if (o.branch && o.aluop == 2'b01 && o.pcsrc == 2'b01) t_brn++;
      @(posedge clk);
      #1;
      t_cyc++;
      o = obs();
      if (o.memread && !o.iord) break;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [6];
    int k;
    tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    k = $urandom_range(0, 7);
    return (k < 6) ? tbl[k] : 6'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instr = 6'h23;
    repeat (2) @(posedge clk);
    #1;
    check("reset state a", 32'(bus_a.state), 32'd0);
    check("reset outs a", 32'(obs_a), 32'd0);
    check("reset state b", 32'(bus_b.state), 32'd0);
    check("reset outs b", 32'(obs_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed, handshake build
    count_instr(6'b000000, 0, 1'b0);
    check("rtype cycles", 32'(t_cyc), 32'd4);
    check("rtype regwrite cycles", 32'(t_rw), 32'd1);
    count_instr(6'b100011, 2, 1'b0);
    check("lw stalled cycles", 32'(t_cyc), 32'd7);
    check("lw memread cycles", 32'(t_mrd), 32'd3);
    check("lw regwrite cycles", 32'(t_rw), 32'd1);
    count_instr(6'b000100, 0, 1'b0);
    check("beq cycles", 32'(t_cyc), 32'd3);
    check("beq branch cycles", 32'(t_brn), 32'd1);
    count_instr(6'b000010, 0, 1'b0);
    check("j cycles", 32'(t_cyc), 32'd3);
    check("j pcwrite cycles", 32'(t_pcw), 32'd1);
    count_instr(6'b111111, 0, 1'b0);
    check("illegal cycles", 32'(t_cyc), 32'd3);
    check("illegal pulse cycles", 32'(t_ill), 32'd1);
    check("illegal writes", 32'(t_rw + t_mw + t_pcw), 32'd0);
    count_instr(6'b101011, 1, 1'b0);
    check("sw stalled cycles", 32'(t_cyc), 32'd5);
    check("sw memwrite cycles", 32'(t_mw), 32'd2);
    count_instr(6'b001000, 0, 1'b0);
    check("addi cycles", 32'(t_cyc), 32'd4);

    repeat (300) run_instr(pick_op(), 1'b1);

    // Asynchronous reset in the middle of a MEMREAD stall
    instr = 6'h23;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (obs_a.memread && obs_a.iord) break;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall before reset", 32'({obs_a.memread, obs_a.iord}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset state", 32'(bus_a.state), 32'd0);
    check("async reset outs", 32'(obs_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("restart at fetch", 32'(obs_a), 32'(exp_ctl(P_F, 1'b1)));

    // Directed and random on the fixed-latency build
    sel_b = 1'b1;
    count_instr(6'b101011, 0, 1'b1);
    check("sw nohs cycles", 32'(t_cyc), 32'd4);
    check("sw nohs memwrite cycles", 32'(t_mw), 32'd1);
    check("sw nohs iord with memwrite", 32'(t_mwi), 32'd1);
    check("sw nohs regwrite cycles", 32'(t_rw), 32'd0);
    count_instr(6'b100011, 0, 1'b1);
    check("lw nohs cycles", 32'(t_cyc), 32'd5);
    repeat (150) run_instr(pick_op(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle main control FSM for the MIPS_V2 datapath; the next generation of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving the shared-ALU/shared-memory datapath one step per cycle. It adds stall-on-memory handshaking (parameter-selectable) and illegal-opcode trapping. It sits between the instruction register's opcode field and every datapath mux and write-enable.

## Interface
- OPCODE_W, 6, opcode field width
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored (single-cycle memory)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  OPCODE_W  opcode from IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, AluSrcA  out  1 each  datapath controls
- AluSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- AluOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, debug

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, TRAP.
- Moore outputs decoded from state only, except the gating noted below. Any control not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00.
  - IRWrite and PCWrite equal the "ready" condition (mem_ready, or 1 when MEM_HANDSHAKE=0).
  - Advance to DECODE on ready; otherwise hold.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00. Dispatch on instr:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEXEC
  - 000010 → JUMP
  - any other opcode → TRAP
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemRead=1, IorD=1. Advance to MEMWB on ready; otherwise hold.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next is FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Advance to FETCH on ready; otherwise hold.
- EXECUTE: AluSrcA=1, AluSrcB=00, AluOp=10. Next is ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0. Next is FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, Branch=1, PCSrc=01. The datapath ANDs Branch with zero. Next is FETCH.
- ADDIEXEC: AluSrcA=1, AluSrcB=10, AluOp=00. Next is ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Next is FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next is FETCH.
- TRAP: illegal_op=1, no writes. Next is FETCH. PC has already advanced by 4, so the instruction behaves as a NOP.
- instr is sampled only in DECODE and MEMADR. Changes in other states have no effect.

## Timing
- State register updates on posedge clk. rst_n low forces state=RESET immediately (asynchronously), including mid-instruction and mid-stall.
- While in RESET every output is 0 and state=0000.
- After rst_n deasserts: first rising edge → FETCH.
- Cycle counts with ready always true (FETCH through the return to FETCH):
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 3.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- During such a stall, MemRead/MemWrite stay asserted. PCWrite, IRWrite and RegWrite are never asserted while stalled.
- mem_ready in any non-memory state is ignored.
- MEM_HANDSHAKE=0 gives the fixed counts above regardless of mem_ready.
- Write enables (PCWrite, IRWrite, RegWrite, MemWrite) are asserted for at most one cycle per instruction, except MemWrite, which is held for the duration of a stall.

## Test plan
- Reset, then instr=000000 with mem_ready=1 → state sequence FETCH, DECODE, EXECUTE, ALUWB, FETCH. RegWrite=1 and RegDst=1 only in the ALUWB cycle.
- lw (100011), mem_ready low for 2 cycles in MEMREAD → 7 cycles total. MemRead high for all 3 MEMREAD cycles. MemToReg=1 and RegWrite=1 for a single cycle.
- sw (101011) with MEM_HANDSHAKE=0 and mem_ready held 0 → 4 cycles. MemWrite=1 for exactly 1 cycle, IorD=1 in that cycle. RegWrite never asserted.
- beq (000100) → 3 cycles. Branch=1, AluOp=01 and PCSrc=01 in BRANCH. j (000010) → PCWrite=1 and PCSrc=10 in JUMP.
- instr=111111 → DECODE then TRAP. illegal_op pulses exactly 1 cycle, then FETCH. No RegWrite, MemWrite or PCWrite in TRAP.
- rst_n pulled low mid-MEMREAD stall (between clock edges) → state=0000 and all outputs 0 immediately. After release, execution restarts at FETCH.
